// File: rtl/io_responder.sv
// io_responder: LSU-facing MMIO responder. Captures one uncached load/store,
// forwards it to the addressed peripheral slot over a valid/ready handshake,
// and returns load data (or an error pulse) to the LSU. Stores are posted.
module io_responder #(
  parameter int          NUM_DEVICES       = 4,
  parameter int          DEV_SEL_LSB       = 16,
  parameter int          TIMEOUT_CYCLES    = 255,
  parameter logic [31:0] MMIO_BASE_ADDRESS = 32'hF000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        io_rd_en,
  input  logic                        io_wr_en,
  input  logic [31:0]                 io_addr,
  input  logic [3:0]                  io_wr_strobe,
  input  logic [31:0]                 io_wr_data,
  output logic                        io_busy,
  output logic                        io_rd_valid,
  output logic [31:0]                 io_rd_data,
  output logic                        io_err,
  output logic [NUM_DEVICES-1:0]      dev_req_valid,
  input  logic [NUM_DEVICES-1:0]      dev_req_ready,
  output logic                        dev_req_we,
  output logic [DEV_SEL_LSB-1:0]      dev_addr,
  output logic [3:0]                  dev_wr_strobe,
  output logic [31:0]                 dev_wr_data,
  input  logic [NUM_DEVICES-1:0]      dev_rsp_valid,
  input  logic [32*NUM_DEVICES-1:0]   dev_rsp_data
);

  localparam int          SLOT_W       = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  // Last counter value still spent waiting; reaching it without completion times out.
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] ERR_DATA     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Captured request
  logic [DEV_SEL_LSB-1:0] addr_reg, addr_next;
  logic [3:0]             strobe_reg, strobe_next;
  logic [31:0]            data_reg, data_next;
  logic                   we_reg, we_next;
  logic [SLOT_W-1:0]      slot_reg, slot_next;
  // Set when the completion must carry io_err (unmapped, both strobes, timeout)
  logic                   err_flag_reg, err_flag_next;
  logic [7:0]             cnt_reg, cnt_next;

  // Registered outputs
  logic                   busy_reg, busy_next;
  logic                   rd_valid_reg, rd_valid_next;
  logic [31:0]            rd_data_reg, rd_data_next;
  logic                   err_out_reg, err_out_next;
  logic [NUM_DEVICES-1:0] req_valid_reg, req_valid_next;

  logic [31:0]            rsp_data_arr [NUM_DEVICES];
  logic [NUM_DEVICES-1:0] slot_onehot_next;
  logic                   in_window;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEVICES; gi++) begin : g_slot
      assign rsp_data_arr[gi]     = dev_rsp_data[32*gi +: 32];
      assign slot_onehot_next[gi] = (slot_next == SLOT_W'(gi));
    end
  endgenerate

  assign in_window = ((io_addr & MMIO_BASE_ADDRESS) == MMIO_BASE_ADDRESS);

  // Next-state and next-output decode; outputs are derived from the state being entered
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    strobe_next   = strobe_reg;
    data_next     = data_reg;
    we_next       = we_reg;
    slot_next     = slot_reg;
    err_flag_next = err_flag_reg;
    cnt_next      = cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (io_rd_en || io_wr_en) begin
          addr_next     = io_addr[DEV_SEL_LSB-1:0];
          strobe_next   = io_wr_strobe;
          data_next     = io_wr_data;
          we_next       = io_wr_en;            // both strobes behave as a write
          slot_next     = io_addr[DEV_SEL_LSB +: SLOT_W];
          cnt_next      = 8'd0;
          err_flag_next = io_rd_en && io_wr_en;
          if (in_window) begin
            state_next = ST_REQ;
          end else begin
            err_flag_next = 1'b1;
            state_next    = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        cnt_next = cnt_reg + 8'd1;
        if (dev_req_ready[slot_reg]) begin
          if (!we_reg) begin
            state_next = ST_WAIT;
          end else if (err_flag_reg) begin
            state_next = ST_RESP;              // accepted, but report the strobe conflict
          end else begin
            state_next = ST_IDLE;              // posted store
          end
        end else if (cnt_reg == TIMEOUT_LAST) begin
          err_flag_next = 1'b1;
          state_next    = ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg + 8'd1;
        if (dev_rsp_valid[slot_reg]) begin
          state_next = ST_RESP;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          err_flag_next = 1'b1;
          state_next    = ST_RESP;
        end
      end
      ST_RESP: begin
        err_flag_next = 1'b0;
        state_next    = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next      = (state_next != ST_IDLE);
    req_valid_next = (state_next == ST_REQ) ? slot_onehot_next : '0;
    rd_valid_next  = (state_next == ST_RESP) && !we_next;
    err_out_next   = (state_next == ST_RESP) && err_flag_next;
    rd_data_next   = '0;
    if ((state_next == ST_RESP) && !we_next) begin
      // Only a WAIT->RESP transition with a real response is error-free for reads
      rd_data_next = err_flag_next ? ERR_DATA : rsp_data_arr[slot_reg];
    end
  end

  // State, captured request and output registers; reset aborts any transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      strobe_reg    <= '0;
      data_reg      <= '0;
      we_reg        <= 1'b0;
      slot_reg      <= '0;
      err_flag_reg  <= 1'b0;
      cnt_reg       <= 8'd0;
      busy_reg      <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
      err_out_reg   <= 1'b0;
      req_valid_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      strobe_reg    <= strobe_next;
      data_reg      <= data_next;
      we_reg        <= we_next;
      slot_reg      <= slot_next;
      err_flag_reg  <= err_flag_next;
      cnt_reg       <= cnt_next;
      busy_reg      <= busy_next;
      rd_valid_reg  <= rd_valid_next;
      rd_data_reg   <= rd_data_next;
      err_out_reg   <= err_out_next;
      req_valid_reg <= req_valid_next;
    end
  end

  assign io_busy       = busy_reg;
  assign io_rd_valid   = rd_valid_reg;
  assign io_rd_data    = rd_data_reg;
  assign io_err        = err_out_reg;
  assign dev_req_valid = req_valid_reg;
  assign dev_req_we    = we_reg;
  assign dev_addr      = addr_reg;
  assign dev_wr_strobe = strobe_reg;
  assign dev_wr_data   = data_reg;

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed stimulus with a completion scoreboard. Stimulus
// pushes each expected LSU completion (kind, data, err, cycle); a negedge
// monitor pops and compares whenever io_rd_valid or io_err is seen.
module tb_io_responder;

  localparam int          ND   = 4;
  localparam int          LSB  = 16;
  localparam int          TMO  = 255;
  localparam logic [31:0] BASE = 32'hF000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             io_rd_en = 1'b0;
  logic             io_wr_en = 1'b0;
  logic [31:0]      io_addr = '0;
  logic [3:0]       io_wr_strobe = '0;
  logic [31:0]      io_wr_data = '0;
  logic             io_busy;
  logic             io_rd_valid;
  logic [31:0]      io_rd_data;
  logic             io_err;
  logic [ND-1:0]    dev_req_valid;
  logic [ND-1:0]    dev_req_ready = '0;
  logic             dev_req_we;
  logic [LSB-1:0]   dev_addr;
  logic [3:0]       dev_wr_strobe;
  logic [31:0]      dev_wr_data;
  logic [ND-1:0]    dev_rsp_valid = '0;
  logic [32*ND-1:0] dev_rsp_data = '0;

  io_responder #(
    .NUM_DEVICES(ND), .DEV_SEL_LSB(LSB), .TIMEOUT_CYCLES(TMO), .MMIO_BASE_ADDRESS(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .io_rd_en(io_rd_en), .io_wr_en(io_wr_en), .io_addr(io_addr),
    .io_wr_strobe(io_wr_strobe), .io_wr_data(io_wr_data),
    .io_busy(io_busy), .io_rd_valid(io_rd_valid), .io_rd_data(io_rd_data), .io_err(io_err),
    .dev_req_valid(dev_req_valid), .dev_req_ready(dev_req_ready), .dev_req_we(dev_req_we),
    .dev_addr(dev_addr), .dev_wr_strobe(dev_wr_strobe), .dev_wr_data(dev_wr_data),
    .dev_rsp_valid(dev_rsp_valid), .dev_rsp_data(dev_rsp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit rd, input logic [31:0] data, input bit err, input int at);
    exp_t e;
    e.rd = rd; e.data = data; e.err = err; e.cyc = at;
    sb.push_back(e);
  endtask

  // Completion monitor
  always @(negedge clk) begin
    if (io_rd_valid || io_err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: rd_valid=%0b err=%0b data=0x%08h at cycle %0d, expected none",
                 io_rd_valid, io_err, io_rd_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn: rd_valid=%0b data=0x%08h err=%0b cycle=%0d", io_rd_valid, io_rd_data, io_err, cyc);
        check("completion_kind", {31'd0, io_rd_valid}, {31'd0, e.rd});
        check("completion_err", {31'd0, io_err}, {31'd0, e.err});
        check("completion_cycle", cyc, e.cyc);
        if (e.rd) check("completion_data", io_rd_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  int t0;

  initial begin
    // Reset state
    #2;
    check("reset_busy", {31'd0, io_busy}, 32'd0);
    check("reset_req_valid", {28'd0, dev_req_valid}, 32'd0);
    check("reset_rd_valid", {31'd0, io_rd_valid}, 32'd0);
    check("reset_dev_addr", {16'd0, dev_addr}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: read slot1, ready at once, response next cycle
    io_rd_en = 1'b1; io_addr = BASE | 32'h0001_0008; dev_req_ready = 4'b0010;
    t0 = cyc;
    push(1'b1, 32'hCAFE_F00D, 1'b0, t0 + 3);
    tick();
    io_rd_en = 1'b0;
    check("rd1_req_valid", {28'd0, dev_req_valid}, 32'h2);
    check("rd1_dev_addr", {16'd0, dev_addr}, 32'h8);
    check("rd1_we", {31'd0, dev_req_we}, 32'd0);
    check("rd1_busy", {31'd0, io_busy}, 32'd1);
    tick();
    check("rd1_wait_valid", {28'd0, dev_req_valid}, 32'd0);
    dev_rsp_valid = 4'b0010; dev_rsp_data[32 +: 32] = 32'hCAFE_F00D;
    tick();
    dev_rsp_valid = '0; dev_req_ready = '0;
    tick(); tick();

    // 2: posted byte store to slot2, ready low for 5 cycles
    io_wr_en = 1'b1; io_addr = BASE | 32'h0002_0004; io_wr_strobe = 4'b0010; io_wr_data = 32'h0000_AB00;
    t0 = cyc;
    tick();
    io_wr_en = 1'b0; io_wr_strobe = '0; io_wr_data = '0;
    for (int k = 1; k <= 6; k++) begin
      check("wr_req_valid", {28'd0, dev_req_valid}, 32'h4);
      check("wr_data", dev_wr_data, 32'h0000_AB00);
      check("wr_strobe", {28'd0, dev_wr_strobe}, 32'h2);
      check("wr_we", {31'd0, dev_req_we}, 32'd1);
      if (k == 6) dev_req_ready = 4'b0100;
      tick();
    end
    dev_req_ready = '0;
    check("wr_done_valid", {28'd0, dev_req_valid}, 32'd0);
    check("wr_done_busy", {31'd0, io_busy}, 32'd0);
    tick();

    // 3: read slot3, accepted but never answered -> timeout
    io_rd_en = 1'b1; io_addr = BASE | 32'h0003_0000; dev_req_ready = 4'b1000;
    t0 = cyc;
    push(1'b1, 32'hFFFF_FFFF, 1'b1, t0 + 1 + TMO);
    tick();
    io_rd_en = 1'b0;
    tick();
    dev_req_ready = '0;
    while (cyc < t0 + TMO) tick();
    check("tmo_still_busy", {31'd0, io_busy}, 32'd1);
    while (cyc < t0 + TMO + 3) tick();
    dev_rsp_valid = 4'b1000; dev_rsp_data[96 +: 32] = 32'h1357_9BDF;
    tick();
    dev_rsp_valid = '0;
    tick();
    check("tmo_late_rsp_busy", {31'd0, io_busy}, 32'd0);

    // 4: read outside the MMIO window
    io_rd_en = 1'b1; io_addr = 32'h0000_1000;
    t0 = cyc;
    push(1'b1, 32'hFFFF_FFFF, 1'b1, t0 + 1);
    tick();
    io_rd_en = 1'b0;
    check("unmapped_req_valid", {28'd0, dev_req_valid}, 32'd0);
    tick();
    check("unmapped_req_valid2", {28'd0, dev_req_valid}, 32'd0);
    tick();

    // 5: request while busy is dropped; wrong-slot response ignored
    io_rd_en = 1'b1; io_addr = BASE | 32'h0000_0010; dev_req_ready = 4'b0001;
    t0 = cyc;
    tick();
    io_addr = BASE | 32'h0001_0020;    // io_rd_en still high: second request while busy
    check("drop_busy", {31'd0, io_busy}, 32'd1);
    tick();
    io_rd_en = 1'b0; dev_req_ready = '0;
    dev_rsp_valid = 4'b0010; dev_rsp_data[32 +: 32] = 32'hBAD0_BAD0;
    tick();
    check("wrong_slot_busy", {31'd0, io_busy}, 32'd1);
    dev_rsp_valid = 4'b0001; dev_rsp_data[0 +: 32] = 32'h1234_5678;
    push(1'b1, 32'h1234_5678, 1'b0, t0 + 4);
    tick();
    dev_rsp_valid = '0;
    tick();
    check("drop_idle_after", {31'd0, io_busy}, 32'd0);
    check("drop_no_req", {28'd0, dev_req_valid}, 32'd0);
    tick();

    // 6: both strobes -> treated as write, error-only completion
    io_rd_en = 1'b1; io_wr_en = 1'b1; io_addr = BASE | 32'h0000_0040;
    io_wr_strobe = 4'b1111; io_wr_data = 32'hDEAD_BEEF; dev_req_ready = 4'b0001;
    t0 = cyc;
    push(1'b0, 32'h0, 1'b1, t0 + 2);
    tick();
    io_rd_en = 1'b0; io_wr_en = 1'b0;
    check("both_we", {31'd0, dev_req_we}, 32'd1);
    tick();
    dev_req_ready = '0;
    tick(); tick();

    // 7: reset asserted during WAIT aborts; next read completes normally
    io_rd_en = 1'b1; io_addr = BASE | 32'h0002_0100; dev_req_ready = 4'b0100;
    tick();
    io_rd_en = 1'b0;
    tick();
    dev_req_ready = '0;
    rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, io_busy}, 32'd0);
    check("rst_req_valid", {28'd0, dev_req_valid}, 32'd0);
    check("rst_rd_valid", {31'd0, io_rd_valid}, 32'd0);
    check("rst_err", {31'd0, io_err}, 32'd0);
    check("rst_dev_addr", {16'd0, dev_addr}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    io_rd_en = 1'b1; io_addr = BASE | 32'h0002_0104; dev_req_ready = 4'b0100;
    t0 = cyc;
    push(1'b1, 32'h0BAD_CAFE, 1'b0, t0 + 3);
    tick();
    io_rd_en = 1'b0;
    check("post_rst_req", {28'd0, dev_req_valid}, 32'h4);
    check("post_rst_addr", {16'd0, dev_addr}, 32'h0104);
    tick();
    dev_rsp_valid = 4'b0100; dev_rsp_data[64 +: 32] = 32'h0BAD_CAFE;
    tick();
    dev_rsp_valid = '0; dev_req_ready = '0;
    tick(); tick(); tick();

    check("pending_completions", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
